// File: rtl/register_file_16x32.sv
// 16-entry architectural register file: two combinational read ports, one write port, r0 reads zero.
// Writes land on the rising clk edge. Reads have zero latency, with an optional same-cycle write bypass. There is no handshake.
module register_file_16x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_wr_en;
  logic                  w_hit1;
  logic                  w_hit2;

  // Reset outranks the write strobe. Writes to address 0 are discarded, so r0 keeps its reset value.
  assign w_wr_en = write_enable && !reset && (write_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_addr] <= write_data;
    end
  end

  // w_wr_en already excludes reset and address 0, so the bypass inherits both suppressions.
  assign w_hit1 = (BYPASS != 0) && w_wr_en && (write_addr == read_addr1);
  assign w_hit2 = (BYPASS != 0) && w_wr_en && (write_addr == read_addr2);

  assign read_data1 = (read_addr1 == '0) ? '0 :
                      w_hit1             ? write_data : r_regs[read_addr1];
  assign read_data2 = (read_addr2 == '0) ? '0 :
                      w_hit2             ? write_data : r_regs[read_addr2];

endmodule
